// File: rtl/btb_update_ctrl_if.sv
// Bundles the execute-update, preload, control and BTB write-port signals of
// btb_update_ctrl. The slave modport is the controller side.
interface btb_update_ctrl_if #(
  parameter int INDEX_WIDTH = 12,
  parameter int DEPTH       = 4
);
  localparam int TW = 32 - INDEX_WIDTH - 2;
  localparam int CW = $clog2(DEPTH) + 1;

  logic                   ex_valid_i;
  logic                   ex_ready_o;
  logic [31:0]            ex_pc_i;
  logic [31:0]            ex_target_i;
  logic                   dbg_valid_i;
  logic                   dbg_ready_o;
  logic [INDEX_WIDTH-1:0] dbg_index_i;
  logic [TW-1:0]          dbg_tag_i;
  logic [31:0]            dbg_target_i;
  logic                   stall_i;
  logic                   flush_i;
  logic                   btb_wren_o;
  logic [INDEX_WIDTH-1:0] btb_wr_index_o;
  logic [TW-1:0]          btb_wr_tag_o;
  logic [31:0]            btb_wr_target_o;
  logic [CW-1:0]          pending_o;

  modport slave (
    input  ex_valid_i, ex_pc_i, ex_target_i,
    input  dbg_valid_i, dbg_index_i, dbg_tag_i, dbg_target_i,
    input  stall_i, flush_i,
    output ex_ready_o, dbg_ready_o,
    output btb_wren_o, btb_wr_index_o, btb_wr_tag_o, btb_wr_target_o, pending_o
  );

  modport master (
    output ex_valid_i, ex_pc_i, ex_target_i,
    output dbg_valid_i, dbg_index_i, dbg_tag_i, dbg_target_i,
    output stall_i, flush_i,
    input  ex_ready_o, dbg_ready_o,
    input  btb_wren_o, btb_wr_index_o, btb_wr_tag_o, btb_wr_target_o, pending_o
  );
endinterface

// File: rtl/btb_update_ctrl.sv
// BTB write-side controller: coalescing queue for execute updates, round-robin
// arbitration against debug preloads, registered single write port.
module btb_update_ctrl #(
  parameter int INDEX_WIDTH = 12,
  parameter int DEPTH       = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  btb_update_ctrl_if.slave  bus
);
  localparam int TW = 32 - INDEX_WIDTH - 2;
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [INDEX_WIDTH-1:0] idx_q [DEPTH];
  logic [TW-1:0]          tag_q [DEPTH];
  logic [31:0]            tgt_q [DEPTH];
  logic [DEPTH-1:0]       valid_q;
  logic [AW-1:0]          head_q;
  logic [AW-1:0]          tail_q;
  logic [CW-1:0]          count_q;
  logic [CW-1:0]          count_d;
  logic                   rr_dbg_last_q;

  logic                   wren_q;
  logic [INDEX_WIDTH-1:0] wr_index_q;
  logic [TW-1:0]          wr_tag_q;
  logic [31:0]            wr_target_q;

  logic [INDEX_WIDTH-1:0] ex_index_s;
  logic [TW-1:0]          ex_tag_s;
  logic [DEPTH-1:0]       hit_vec_s;
  logic [AW-1:0]          hit_slot_s;
  logic                   hit_s;
  logic                   full_s;
  logic                   ex_ready_s;
  logic                   q_avail_s;
  logic                   contested_s;
  logic                   grant_q_s;
  logic                   grant_d_s;
  logic                   accept_s;
  logic                   coalesce_s;
  logic                   push_s;
  logic                   pc_unused_s;

  assign ex_index_s  = bus.ex_pc_i[INDEX_WIDTH+1:2];
  assign ex_tag_s    = bus.ex_pc_i[31:INDEX_WIDTH+2];
  assign pc_unused_s = ^bus.ex_pc_i[1:0];

  // Index match against every valid entry; duplicates never exist, so one hit at most
  always_comb begin
    hit_vec_s  = '0;
    hit_slot_s = '0;
    for (int i = 0; i < DEPTH; i++) begin
      hit_vec_s[i] = valid_q[i] && (idx_q[i] == ex_index_s);
      if (hit_vec_s[i]) begin
        hit_slot_s = AW'(i);
      end else begin
        hit_slot_s = hit_slot_s;
      end
    end
  end

  assign hit_s      = bus.ex_valid_i && (|hit_vec_s);
  assign full_s     = (count_q == CW'(DEPTH));
  assign ex_ready_s = !bus.flush_i && (!full_s || hit_s);
  assign q_avail_s  = (count_q != {CW{1'b0}});

  // Round-robin grant between queue head and preload port
  always_comb begin
    grant_q_s   = 1'b0;
    grant_d_s   = 1'b0;
    contested_s = q_avail_s && bus.dbg_valid_i;
    if (!bus.stall_i && !bus.flush_i) begin
      if (contested_s) begin
        grant_q_s = rr_dbg_last_q;
        grant_d_s = !rr_dbg_last_q;
      end else begin
        grant_q_s = q_avail_s;
        grant_d_s = bus.dbg_valid_i;
      end
    end else begin
      grant_q_s = 1'b0;
      grant_d_s = 1'b0;
    end
  end

  // A hit on the head being popped frees that slot, so it becomes an ordinary push
  assign accept_s   = bus.ex_valid_i && ex_ready_s;
  assign coalesce_s = accept_s && hit_s && !(grant_q_s && hit_vec_s[head_q]);
  assign push_s     = accept_s && !coalesce_s;

  always_comb begin
    count_d = count_q + CW'(push_s) - CW'(grant_q_s);
  end

  // Queue storage, pointers and occupancy
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      valid_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        idx_q[i] <= '0;
        tag_q[i] <= '0;
        tgt_q[i] <= 32'h0000_0000;
      end
    end else if (bus.flush_i) begin
      valid_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (grant_q_s) begin
        valid_q[head_q] <= 1'b0;
        head_q          <= head_q + AW'(1);
      end
      if (coalesce_s) begin
        tag_q[hit_slot_s] <= ex_tag_s;
        tgt_q[hit_slot_s] <= bus.ex_target_i;
      end
      if (push_s) begin
        valid_q[tail_q] <= 1'b1;
        idx_q[tail_q]   <= ex_index_s;
        tag_q[tail_q]   <= ex_tag_s;
        tgt_q[tail_q]   <= bus.ex_target_i;
        tail_q          <= tail_q + AW'(1);
      end
      count_q <= count_d;
    end
  end

  // Fairness pointer moves only when both sources competed
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rr_dbg_last_q <= 1'b1;
    end else if (contested_s && (grant_q_s || grant_d_s)) begin
      rr_dbg_last_q <= grant_d_s;
    end else begin
      rr_dbg_last_q <= rr_dbg_last_q;
    end
  end

  // Registered BTB write port
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wren_q      <= 1'b0;
      wr_index_q  <= '0;
      wr_tag_q    <= '0;
      wr_target_q <= 32'h0000_0000;
    end else begin
      wren_q <= grant_q_s || grant_d_s;
      if (grant_q_s) begin
        wr_index_q  <= idx_q[head_q];
        wr_tag_q    <= tag_q[head_q];
        wr_target_q <= tgt_q[head_q];
      end else if (grant_d_s) begin
        wr_index_q  <= bus.dbg_index_i;
        wr_tag_q    <= bus.dbg_tag_i;
        wr_target_q <= bus.dbg_target_i;
      end else begin
        wr_index_q  <= wr_index_q;
        wr_tag_q    <= wr_tag_q;
        wr_target_q <= wr_target_q;
      end
    end
  end

  assign bus.ex_ready_o      = ex_ready_s;
  assign bus.dbg_ready_o     = grant_d_s;
  assign bus.btb_wren_o      = wren_q;
  assign bus.btb_wr_index_o  = wr_index_q;
  assign bus.btb_wr_tag_o    = wr_tag_q;
  assign bus.btb_wr_target_o = wr_target_q;
  assign bus.pending_o       = count_q;
endmodule

// File: tb/tb_btb_update_ctrl.sv
// Directed self-checking bench for btb_update_ctrl (INDEX_WIDTH=12, DEPTH=4).
module tb_btb_update_ctrl;
  logic clk_i = 1'b0;
  logic rst_i = 1'b0;
  int   total = 0;
  int   bad   = 0;

  btb_update_ctrl_if #(.INDEX_WIDTH(12), .DEPTH(4)) bif ();

  btb_update_ctrl #(.INDEX_WIDTH(12), .DEPTH(4)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bif.slave)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic ex_drive(input logic v, input logic [31:0] pc, input logic [31:0] tgt);
    bif.ex_valid_i  = v;
    bif.ex_pc_i     = pc;
    bif.ex_target_i = tgt;
  endtask

  task automatic chk_wr(input string tag, input logic [11:0] idx, input logic [17:0] tg,
                        input logic [31:0] tgt);
    check({tag, "_wren"}, 64'(bif.btb_wren_o), 64'd1);
    check({tag, "_idx"},  64'(bif.btb_wr_index_o), 64'(idx));
    check({tag, "_tag"},  64'(bif.btb_wr_tag_o), 64'(tg));
    check({tag, "_tgt"},  64'(bif.btb_wr_target_o), 64'(tgt));
  endtask

  initial begin
    ex_drive(1'b0, 32'h0, 32'h0);
    bif.dbg_valid_i  = 1'b0;
    bif.dbg_index_i  = 12'h000;
    bif.dbg_tag_i    = 18'h00000;
    bif.dbg_target_i = 32'h0;
    bif.stall_i      = 1'b0;
    bif.flush_i      = 1'b0;
    #1;
    check("rst_pending", 64'(bif.pending_o), 64'd0);
    check("rst_wren",    64'(bif.btb_wren_o), 64'd0);
    check("rst_idx",     64'(bif.btb_wr_index_o), 64'd0);
    check("rst_tgt",     64'(bif.btb_wr_target_o), 64'd0);
    @(negedge clk_i);
    rst_i = 1'b1;

    // basic latency: pc 0x4A3C -> index pc[13:2]=0x28F, tag pc[31:14]=1
    ex_drive(1'b1, 32'h0000_4A3C, 32'h0000_1000);
    #1;
    check("lat_ready", 64'(bif.ex_ready_o), 64'd1);
    tick();
    ex_drive(1'b0, 32'h0, 32'h0);
    check("lat_pend1", 64'(bif.pending_o), 64'd1);
    check("lat_wren0", 64'(bif.btb_wren_o), 64'd0);
    tick();
    chk_wr("lat", 12'h28F, 18'h00001, 32'h0000_1000);
    check("lat_pend0", 64'(bif.pending_o), 64'd0);
    tick();
    check("lat_once", 64'(bif.btb_wren_o), 64'd0);

    // coalescing under stall
    bif.stall_i = 1'b1;
    ex_drive(1'b1, 32'h0000_0100, 32'h0000_0200); tick();
    ex_drive(1'b1, 32'h0000_0100, 32'h0000_0300); tick();
    ex_drive(1'b1, 32'h0000_0104, 32'h0000_0400); tick();
    ex_drive(1'b0, 32'h0, 32'h0);
    check("coal_pend", 64'(bif.pending_o), 64'd2);
    check("coal_stall_wren", 64'(bif.btb_wren_o), 64'd0);
    bif.stall_i = 1'b0;
    tick();
    chk_wr("coal_w1", 12'h040, 18'h00000, 32'h0000_0300);
    tick();
    chk_wr("coal_w2", 12'h041, 18'h00000, 32'h0000_0400);
    tick();
    check("coal_end_wren", 64'(bif.btb_wren_o), 64'd0);
    check("coal_end_pend", 64'(bif.pending_o), 64'd0);

    // full queue
    bif.stall_i = 1'b1;
    ex_drive(1'b1, 32'h0000_0200, 32'h0000_00A0); tick();
    ex_drive(1'b1, 32'h0000_0204, 32'h0000_00A1); tick();
    ex_drive(1'b1, 32'h0000_0208, 32'h0000_00A2); tick();
    ex_drive(1'b1, 32'h0000_020C, 32'h0000_00A3); tick();
    check("full_pend", 64'(bif.pending_o), 64'd4);
    ex_drive(1'b1, 32'h0000_0210, 32'h0000_00A4); #1;
    check("full_new_ready", 64'(bif.ex_ready_o), 64'd0);
    ex_drive(1'b1, 32'h0000_0204, 32'h0000_00B1); #1;
    check("full_hit_ready", 64'(bif.ex_ready_o), 64'd1);
    tick();
    check("full_coal_pend", 64'(bif.pending_o), 64'd4);
    bif.stall_i = 1'b0;
    ex_drive(1'b1, 32'h0000_0200, 32'h0000_00B0); #1;
    check("full_head_ready", 64'(bif.ex_ready_o), 64'd1);
    tick();
    ex_drive(1'b0, 32'h0, 32'h0);
    check("full_pp_pend", 64'(bif.pending_o), 64'd4);
    chk_wr("full_w1", 12'h080, 18'h00000, 32'h0000_00A0);
    tick(); chk_wr("full_w2", 12'h081, 18'h00000, 32'h0000_00B1);
    tick(); chk_wr("full_w3", 12'h082, 18'h00000, 32'h0000_00A2);
    tick(); chk_wr("full_w4", 12'h083, 18'h00000, 32'h0000_00A3);
    tick(); chk_wr("full_w5", 12'h080, 18'h00000, 32'h0000_00B0);
    check("full_end_pend", 64'(bif.pending_o), 64'd0);
    tick();
    check("full_end_wren", 64'(bif.btb_wren_o), 64'd0);

    // round-robin: execute wins the first conflict
    bif.stall_i = 1'b1;
    ex_drive(1'b1, 32'h0000_0300, 32'h0000_0C00); tick();
    ex_drive(1'b1, 32'h0000_0304, 32'h0000_0C04); tick();
    ex_drive(1'b0, 32'h0, 32'h0);
    bif.stall_i      = 1'b0;
    bif.dbg_valid_i  = 1'b1;
    bif.dbg_index_i  = 12'h123;
    bif.dbg_tag_i    = 18'h15555;
    bif.dbg_target_i = 32'h0000_D000;
    #1;
    check("rr_dbg_rdy0", 64'(bif.dbg_ready_o), 64'd0);
    tick();
    chk_wr("rr_ex1", 12'h0C0, 18'h00000, 32'h0000_0C00);
    check("rr_dbg_rdy1", 64'(bif.dbg_ready_o), 64'd1);
    tick();
    chk_wr("rr_dbg1", 12'h123, 18'h15555, 32'h0000_D000);
    check("rr_dbg_rdy2", 64'(bif.dbg_ready_o), 64'd0);
    tick();
    chk_wr("rr_ex2", 12'h0C1, 18'h00000, 32'h0000_0C04);
    check("rr_dbg_rdy3", 64'(bif.dbg_ready_o), 64'd1);
    bif.dbg_target_i = 32'h0000_E000;
    tick();
    chk_wr("rr_dbg2", 12'h123, 18'h15555, 32'h0000_E000);
    bif.dbg_valid_i = 1'b0;
    tick();
    check("rr_end_wren", 64'(bif.btb_wren_o), 64'd0);

    // flush: only the already-registered write issues
    bif.stall_i = 1'b1;
    ex_drive(1'b1, 32'h0000_0400, 32'h0000_0F00); tick();
    ex_drive(1'b1, 32'h0000_0404, 32'h0000_0F04); tick();
    ex_drive(1'b1, 32'h0000_0408, 32'h0000_0F08); tick();
    ex_drive(1'b0, 32'h0, 32'h0);
    check("fl_pend3", 64'(bif.pending_o), 64'd3);
    bif.stall_i = 1'b0;
    tick();
    check("fl_pend2", 64'(bif.pending_o), 64'd2);
    bif.flush_i     = 1'b1;
    bif.dbg_valid_i = 1'b1;
    ex_drive(1'b1, 32'h0000_040C, 32'h0000_0F0C);
    #1;
    check("fl_ex_rdy", 64'(bif.ex_ready_o), 64'd0);
    check("fl_dbg_rdy", 64'(bif.dbg_ready_o), 64'd0);
    chk_wr("fl_prev", 12'h100, 18'h00000, 32'h0000_0F00);
    tick();
    bif.flush_i     = 1'b0;
    bif.dbg_valid_i = 1'b0;
    ex_drive(1'b0, 32'h0, 32'h0);
    check("fl_pend0", 64'(bif.pending_o), 64'd0);
    check("fl_wren0", 64'(bif.btb_wren_o), 64'd0);
    tick();
    check("fl_after_wren", 64'(bif.btb_wren_o), 64'd0);

    // flush together with stall still empties the queue
    bif.stall_i = 1'b1;
    ex_drive(1'b1, 32'h0000_0600, 32'h0000_0600); tick();
    ex_drive(1'b0, 32'h0, 32'h0);
    bif.flush_i = 1'b1;
    tick();
    bif.flush_i = 1'b0;
    bif.stall_i = 1'b0;
    check("flst_pend", 64'(bif.pending_o), 64'd0);
    tick();
    check("flst_wren", 64'(bif.btb_wren_o), 64'd0);

    // asynchronous reset mid-stream
    bif.stall_i = 1'b1;
    ex_drive(1'b1, 32'h0000_0500, 32'h0000_0500); tick();
    ex_drive(1'b1, 32'h0000_0504, 32'h0000_0504); tick();
    ex_drive(1'b1, 32'h0000_0508, 32'h0000_0508); tick();
    ex_drive(1'b0, 32'h0, 32'h0);
    bif.stall_i = 1'b0;
    tick();
    check("mrst_pre_wren", 64'(bif.btb_wren_o), 64'd1);
    #2;
    rst_i = 1'b0;
    #1;
    check("mrst_pend", 64'(bif.pending_o), 64'd0);
    check("mrst_wren", 64'(bif.btb_wren_o), 64'd0);
    @(negedge clk_i);
    rst_i = 1'b1;
    tick();
    check("mrst_post_wren1", 64'(bif.btb_wren_o), 64'd0);
    check("mrst_post_pend", 64'(bif.pending_o), 64'd0);
    tick();
    check("mrst_post_wren2", 64'(bif.btb_wren_o), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
